// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key expansion sequencer: one round key per cycle into an 11-entry store, registered read port.
// SubWord is delegated to an external combinational S-box driven through sub_in/sub_out while busy.
module aes128_key_sched_ctrl #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [32*NK-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              busy,
  output logic              keys_valid,
  output logic [31:0]       sub_in,
  input  logic [31:0]       sub_out,
  input  logic              rk_rd_en,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     r_q, r_d;
  logic [127:0]   ks_q [0:NR];
  logic [127:0]   rk_data_q;
  logic [127:0]   prev_rk, next_rk, rd_val;
  logic [31:0]    rot_w, n0, n1, n2, n3;
  logic           load, wr_en;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign key_ready  = (state_q != S_EXPAND);
  assign busy       = (state_q == S_EXPAND);
  assign keys_valid = (state_q == S_DONE);
  assign load       = key_valid && key_ready;
  assign rk_data    = rk_data_q;

  // Round r is derived from the round r-1 entry already in the store.
  always_comb begin
    prev_rk = '0;
    rd_val  = '0;
    for (int i = 0; i <= NR; i++) begin
      if (r_q - 4'd1 == 4'(i)) prev_rk = ks_q[i];
      if (rk_idx == 4'(i))     rd_val  = ks_q[i];
    end
    rot_w   = {prev_rk[23:0], prev_rk[31:24]};
    sub_in  = busy ? rot_w : 32'h0;
    n0      = prev_rk[127:96] ^ sub_out ^ {rcon(r_q), 24'h0};
    n1      = prev_rk[95:64] ^ n0;
    n2      = prev_rk[63:32] ^ n1;
    n3      = prev_rk[31:0]  ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (key_valid) begin
          state_d = S_EXPAND;
          r_d     = 4'd1;
        end
      end
      S_EXPAND: begin
        wr_en = 1'b1;
        if (r_q == 4'(NR)) begin
          state_d = S_DONE;
          r_d     = 4'd0;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      r_q       <= 4'd0;
      rk_data_q <= '0;
      for (int i = 0; i <= NR; i++) ks_q[i] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      if (load) begin
        ks_q[0] <= key_in;
      end else if (wr_en) begin
        for (int i = 1; i <= NR; i++)
          if (r_q == 4'(i)) ks_q[i] <= next_rk;
      end
      // keys_valid is still the pre-edge value, so a read on a handshake edge sees the old set.
      if (rk_rd_en)
        rk_data_q <= (keys_valid && rk_idx <= 4'(NR)) ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for aes128_key_sched_ctrl with an AES S-box model on sub_out.
module tb_aes128_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, busy, keys_valid;
  logic [31:0]  sub_in, sub_out;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]], sbox[sub_in[15:8]], sbox[sub_in[7:0]]};

  aes128_key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .sub_in     (sub_in),
    .sub_out    (sub_out),
    .rk_rd_en   (rk_rd_en),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rk_rd_en = 1'b1;
    rk_idx   = idx;
    tick();
    rk_rd_en = 1'b0;
    check(name, rk_data, exp);
  endtask

  // Handshake plus full 10-cycle expansion; optionally keeps key_valid high with another key.
  task automatic load_key(input logic [127:0] k, input bit hold_other, input logic [31:0] exp_sub1);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    check("sub_in_round1", {96'h0, sub_in}, {96'h0, exp_sub1});
    if (hold_other) key_in = ~k;
    else            key_valid = 1'b0;
    check("flags_after_hs", {125'h0, key_ready, busy, keys_valid}, 128'b010);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("flags_expand", {125'h0, key_ready, busy, keys_valid}, 128'b010);
    end
    key_valid = 1'b0;
    tick();
    check("flags_done", {125'h0, key_ready, busy, keys_valid}, 128'b101);
    check("sub_in_done", {96'h0, sub_in}, 128'h0);
  endtask

  initial begin
    tbl[0] = '{4'd0,  FIPS_KEY};
    tbl[1] = '{4'd1,  FIPS_R1};
    tbl[2] = '{4'd10, FIPS_R10};
    tbl[3] = '{4'd11, 128'h0};
    tbl[4] = '{4'd15, 128'h0};

    reset = 1'b1; key_in = '0; key_valid = 1'b0; rk_rd_en = 1'b0; rk_idx = '0;
    repeat (3) tick();
    check("rst_rk_data", rk_data, 128'h0);
    check("rst_flags", {126'h0, busy, keys_valid}, 128'b00);
    reset = 1'b0;
    tick();
    check("idle_key_ready", {127'h0, key_ready}, 128'h1);
    check("idle_sub_in", {96'h0, sub_in}, 128'h0);
    rd(4'd0, 128'h0, "rd_before_keys");

    // Plain FIPS-197 expansion, then the read table.
    load_key(FIPS_KEY, 1'b0, 32'hcf4f3c09);
    for (int i = 0; i < 5; i++) rd(tbl[i].idx, tbl[i].exp, $sformatf("rd_tbl_idx%0d", tbl[i].idx));

    // key_valid held with a different key during expansion must be ignored.
    load_key(FIPS_KEY, 1'b1, 32'hcf4f3c09);
    repeat (2) tick();
    check("no_second_expand", {126'h0, busy, keys_valid}, 128'b01);
    for (int i = 0; i < 5; i++) rd(tbl[i].idx, tbl[i].exp, $sformatf("rd_hold_idx%0d", tbl[i].idx));

    // Reset in the middle of an expansion.
    key_in = FIPS_KEY; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midrst_flags", {125'h0, key_ready, busy, keys_valid}, 128'b100);
    check("midrst_rk_data", rk_data, 128'h0);
    tick();
    reset = 1'b0;
    tick();
    rd(4'd0, 128'h0, "midrst_rd0");
    rd(4'd1, 128'h0, "midrst_rd1");
    load_key(FIPS_KEY, 1'b0, 32'hcf4f3c09);
    rd(4'd10, FIPS_R10, "after_midrst_rd10");

    // Zero key, then FIPS key loaded in DONE with a read on the handshake edge.
    load_key(128'h0, 1'b0, 32'h0);
    rd(4'd1, ZERO_R1, "zero_rd1");
    rd(4'd10, ZERO_R10, "zero_rd10");
    key_in = FIPS_KEY; key_valid = 1'b1;
    rk_rd_en = 1'b1; rk_idx = 4'd10;
    tick();
    key_valid = 1'b0; rk_rd_en = 1'b0;
    check("hs_edge_old_set", rk_data, ZERO_R10);
    check("hs_edge_flags", {126'h0, busy, keys_valid}, 128'b10);
    rd(4'd10, 128'h0, "rd_during_expand");
    for (int n = 0; n < 20 && !keys_valid; n++) tick();
    check("b2b_keys_valid", {127'h0, keys_valid}, 128'h1);
    rd(4'd10, FIPS_R10, "b2b_rd10");
    rd(4'd1, FIPS_R1, "b2b_rd1");
    rd(4'd0, FIPS_KEY, "b2b_rd0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
